// File: rtl/pipe_elastic_latch_pkg.sv
// Shared types for pipeline latches.
// word_t payload, per-stage hold/flush bundle.
package pipe_elastic_latch_pkg;

  typedef logic [31:0] word_t;

  localparam int WORD_W = $bits(word_t);

  localparam int PIPE_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic hold;
    logic flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipe_elastic_latch_if.sv
// valid/ready/data handshake between stages.
// master drives valid/data, slave drives ready.
interface pipe_elastic_latch_if
  import pipe_elastic_latch_pkg::*;
#(
  parameter int DATA_W = WORD_W
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating accumulator, sync active-low clear.
// Ports: CLK, clr_n, inc_en, inc_val -> value.
module sat_counter #(
  parameter int WIDTH = 16,
  parameter int INC_W = 2
) (
  input  logic             CLK,
  input  logic             clr_n,
  input  logic             inc_en,
  input  logic [INC_W-1:0] inc_val,
  output logic [WIDTH-1:0] value
);

  localparam int MAX_W =
    (WIDTH > INC_W) ? WIDTH : INC_W;
  localparam int SUM_W = MAX_W + 1;

  localparam logic [SUM_W-1:0] TOP =
    SUM_W'({WIDTH{1'b1}});

  logic [SUM_W-1:0] sum;

  // one spare bit so the overflow is visible
  assign sum = SUM_W'(value)
             + SUM_W'(inc_val);

  always_ff @(posedge CLK) begin
    if (!clr_n) begin
      value <= '0;
    end else if (inc_en) begin
      if (sum > TOP) begin
        value <= '1;
      end else begin
        value <= sum[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/pipe_elastic_latch.sv
// Elastic DEPTH-entry latch between two stages.
// Ports: CLK, nRST, up (slave), dn (master),
//        hold, flush, count, drop_count.
module pipe_elastic_latch
  import pipe_elastic_latch_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int DEPTH  = PIPE_DEPTH_DEFAULT,
  parameter int DROP_W = 16
) (
  input  logic CLK,
  input  logic nRST,

  pipe_elastic_latch_if.slave  up,
  pipe_elastic_latch_if.master dn,

  input  logic hold,
  input  logic flush,

  output logic [$clog2(DEPTH):0] count,
  output logic [DROP_W-1:0]      drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  pipe_ctrl_t ctrl;
  logic       push;
  logic       pop;

  assign ctrl.hold  = hold;
  assign ctrl.flush = flush;

  // ready ignores dn.ready: no full bypass
  assign up.ready = nRST
                 && !ctrl.hold
                 && (cnt < FULL);

  assign dn.valid = nRST
                 && !ctrl.hold
                 && (cnt != '0);

  assign dn.data = mem[rd_ptr];

  assign push = up.valid && up.ready;
  assign pop  = dn.valid && dn.ready;

  assign count = cnt;

  // hold needs no branch: it already
  // forces push = pop = 0
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (ctrl.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt <= cnt
           + CNT_W'(push)
           - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST && !ctrl.flush && push) begin
      mem[wr_ptr] <= up.data;
    end
  end

  // squashed entries = occupancy at flush
  sat_counter #(
    .WIDTH (DROP_W),
    .INC_W (CNT_W)
  ) u_drop (
    .CLK     (CLK),
    .clr_n   (nRST),
    .inc_en  (ctrl.flush),
    .inc_val (cnt),
    .value   (drop_count)
  );

endmodule

// File: doc/pipe_elastic_latch.md
Name: pipe_elastic_latch

Overview:
Parametrised successor to the fixed fetch/decode/exec/mem pipeline latches. It holds up to DEPTH payload words between two pipeline stages, using a valid/ready handshake on both sides. It supports stage freeze (hold), synchronous flush and a saturating count of squashed entries. It sits between any two datapath stages and lets a stage stall without forcing the upstream stage to stall on the same cycle.

Parameters:
DATA_W, 32, payload width in bits (word_t width from cpu_types_pkg).
DEPTH, 2, number of buffered entries; power of two, >= 2.
DROP_W, 16, width of the squashed-entry counter.

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
in_valid  in  1  upstream stage presents a payload
in_ready  out  1  latch can accept a payload this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  head entry is available downstream
out_ready  in  1  downstream consumes the head entry this cycle
out_data  out  DATA_W  head entry payload
hold  in  1  freeze: no push, no pop
flush  in  1  squash all contents (branch/jump redirect)
count  out  $clog2(DEPTH)+1  entries currently held
drop_count  out  DROP_W  total entries squashed by flush, saturating

Behaviour:
- Storage: circular buffer mem[DEPTH]. Write pointer wr_ptr and read pointer rd_ptr are each $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. The occupancy register cnt drives count.
- Reset (nRST low at a rising edge): wr_ptr = rd_ptr = cnt = 0 and drop_count = 0. Contents of mem are don't-care.
- While nRST is low: in_ready = 0 and out_valid = 0, combinationally.
- in_ready = nRST && !hold && (cnt < DEPTH). It is independent of out_ready, so there is no full-bypass path.
- out_valid = nRST && !hold && (cnt != 0).
- out_data = mem[rd_ptr] at all times. Its value is don't-care when out_valid = 0.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- Latency: a word pushed at edge t appears on out_data/out_valid after edge t (one cycle). There is no combinational in_data -> out_data path.
- Normal update at the edge:
  - push: mem[wr_ptr] <= in_data and wr_ptr increments.
  - pop: rd_ptr increments.
  - cnt <= cnt + push - pop.
- Simultaneous push and pop with 0 < cnt < DEPTH: both take effect and cnt is unchanged.
- Full (cnt = DEPTH): in_ready = 0, and a pop frees a slot for the next cycle.
- Empty (cnt = 0): out_valid = 0, and a push lands next cycle.
- Flush (priority over push and pop, hold ignored):
  - wr_ptr <= 0, rd_ptr <= 0, cnt <= 0.
  - drop_count <= min(drop_count + cnt, 2^DROP_W - 1).
  - A push offered in the flush cycle is discarded and not counted.
  - A pop handshake in the flush cycle is void; the downstream stage must treat flush as squashing its sampled data.
  - in_ready and out_valid are still driven by the formulas above during the flush cycle.
- Hold (without flush): pointers, cnt and mem are unchanged, and in_ready = out_valid = 0.
- Reset asserted mid-transfer: all buffered data is lost. drop_count clears and does not count the lost entries.
- drop_count saturates at all-ones and never wraps.

Decomposition:
- cpu_types_pkg: word_t is used for the default DATA_W.
- New pipeline_pkg:
  - typedef pipe_ctrl_t struct {hold, flush} per stage, driven by the hazard unit.
  - Constant PIPE_DEPTH_DEFAULT = 2.
- One sub-module, sat_counter (parameters WIDTH and INC_W; inputs inc_en and inc_val; synchronous active-low clear). drop_count is instantiated from it.

Test Plan:
- Reset, then push 0xDEADBEEF with out_ready=0 -> after the next edge out_valid=1, out_data=0xDEADBEEF, count=1, in_ready=1.
- DEPTH=2: push 0x11 then 0x22 with out_ready=0 -> count=2 and in_ready=0. Hold in_valid=1 with 0x33 and raise out_ready -> pops 0x11; 0x33 enters one cycle later; order out is 0x11, 0x22, 0x33.
- Continuous push and pop every cycle for 10 words 0..9 -> count stays 1 and output order is 0..9 across pointer wrap. Repeat with DEPTH=4.
- Fill to count=2, then assert flush together with in_valid=1 (0x44) -> next cycle count=0, out_valid=0, drop_count=2, and 0x44 never appears.
- hold=1 with count=1, in_valid=1, out_ready=1 for 3 cycles -> in_ready=out_valid=0 and count=1. Release -> head data unchanged.
- DROP_W=2: perform three flushes with count=2 each -> drop_count goes 2, 3, 3 (saturates). nRST=0 for one edge -> drop_count=0, count=0.
